// File: rtl/sprite_line_sequencer_pkg.sv
// Shared graphics definitions for the sprite line sequencer: FSM encoding and line geometry.
package sprite_line_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StRender = 2'd2,
        StDone   = 2'd3
    } seq_state_e;

    localparam int unsigned LineWidthDefault  = 640;
    localparam int unsigned RdIdxWidth        = 10;
    localparam int unsigned StartDelayDefault = 2;
    localparam int unsigned OverrunWidth      = 8;

    // The line buffer erases its 4 banks in parallel, one word per bank per cycle.
    localparam int unsigned EraseBanks = 4;

    function automatic int unsigned erase_cycles(int unsigned line_width);
        return line_width / EraseBanks;
    endfunction

    localparam int unsigned EraseCyclesDefault = erase_cycles(LineWidthDefault);

endpackage

// File: rtl/sprite_line_sequencer_if.sv
// Timing/control bundle between the video timing, renderer, composer and the line sequencer.
interface sprite_line_sequencer_if;
    import sprite_line_sequencer_pkg::*;

    logic                     enable;
    logic                     line_swap;
    logic                     display_start;
    logic                     pix_en;
    logic                     display_end;
    logic                     render_done;
    logic                     status_clr;
    logic                     active_render_buffer;
    logic                     render_start;
    logic                     render_abort;
    logic [RdIdxWidth-1:0]    composer_rd_idx;
    logic                     composer_erase_start;
    logic [OverrunWidth-1:0]  render_overrun;
    logic                     erase_overrun;

    modport master (
        output enable, line_swap, display_start, pix_en, display_end, render_done, status_clr,
        input  active_render_buffer, render_start, render_abort, composer_rd_idx,
               composer_erase_start, render_overrun, erase_overrun
    );

    modport slave (
        input  enable, line_swap, display_start, pix_en, display_end, render_done, status_clr,
        output active_render_buffer, render_start, render_abort, composer_rd_idx,
               composer_erase_start, render_overrun, erase_overrun
    );

endinterface

// File: rtl/sprite_erase_timer.sv
// Line-buffer erase timer: registered start pulse plus a reloadable busy down-counter.
module sprite_erase_timer #(
    parameter int unsigned Cycles = 160
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic busy_o,
    output logic start_pulse_o
);

    localparam int unsigned CntW = $clog2(Cycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q;

    // A new start while busy simply reloads the full erase window.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = CntW'(Cycles);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= start_i;
        end
    end

    assign busy_o        = (cnt_q != '0);
    assign start_pulse_o = pulse_q;

endmodule

// File: rtl/sprite_line_sequencer.sv
// Double-buffered sprite line sequencer: buffer select, render start/abort, erase trigger,
// composer read index and overrun status.
module sprite_line_sequencer
    import sprite_line_sequencer_pkg::*;
#(
    parameter int unsigned LINE_WIDTH   = LineWidthDefault,
    parameter int unsigned ERASE_CYCLES = erase_cycles(LINE_WIDTH),
    parameter int unsigned START_DELAY  = StartDelayDefault
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    sprite_line_sequencer_if.slave  seq_bus
);

    localparam int unsigned DlyW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [RdIdxWidth-1:0] LastIdx = RdIdxWidth'(LINE_WIDTH - 1);
    localparam logic [OverrunWidth-1:0] OvMax = '1;

    seq_state_e              state_q;
    logic [DlyW-1:0]         dly_q;
    logic                    buf_q;
    logic                    start_q;
    logic                    abort_q;
    logic [RdIdxWidth-1:0]   rd_idx_q, rd_idx_d;
    logic [OverrunWidth-1:0] rov_q, rov_d;
    logic                    eov_q, eov_d;
    logic                    erase_busy;
    logic                    erase_pulse;
    logic                    rov_inc;

    sprite_erase_timer #(
        .Cycles(ERASE_CYCLES)
    ) u_erase_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (seq_bus.display_end & seq_bus.enable),
        .busy_o       (erase_busy),
        .start_pulse_o(erase_pulse)
    );

    // Swap always toggles the buffer; enable only decides whether a new render is launched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            dly_q   <= '0;
            buf_q   <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
            if (seq_bus.line_swap) begin
                buf_q   <= ~buf_q;
                abort_q <= (state_q == StRender);
                if (seq_bus.enable) begin
                    state_q <= StDelay;
                    dly_q   <= DlyW'(START_DELAY - 1);
                end else begin
                    state_q <= StIdle;
                end
            end else if (!seq_bus.enable) begin
                abort_q <= (state_q == StRender);
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StDelay: begin
                        if (dly_q == '0) begin
                            start_q <= 1'b1;
                            state_q <= StRender;
                        end else begin
                            dly_q <= dly_q - DlyW'(1);
                        end
                    end
                    StRender: if (seq_bus.render_done) state_q <= StDone;
                    default: ;
                endcase
            end
        end
    end

    assign rov_inc = seq_bus.line_swap & seq_bus.enable & (state_q == StRender);

    // Overrun events beat a coincident clear.
    always_comb begin
        rov_d = rov_q;
        if (rov_inc) begin
            if (seq_bus.status_clr) begin
                rov_d = OverrunWidth'(1);
            end else if (rov_q != OvMax) begin
                rov_d = rov_q + OverrunWidth'(1);
            end
        end else if (seq_bus.status_clr) begin
            rov_d = '0;
        end

        eov_d = eov_q;
        if (seq_bus.line_swap && erase_busy) begin
            eov_d = 1'b1;
        end else if (seq_bus.status_clr) begin
            eov_d = 1'b0;
        end

        rd_idx_d = rd_idx_q;
        if (seq_bus.display_start) begin
            rd_idx_d = '0;
        end else if (seq_bus.pix_en && rd_idx_q != LastIdx) begin
            rd_idx_d = rd_idx_q + RdIdxWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rov_q    <= '0;
            eov_q    <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            rov_q    <= rov_d;
            eov_q    <= eov_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    assign seq_bus.active_render_buffer = buf_q;
    assign seq_bus.render_start         = start_q;
    assign seq_bus.render_abort         = abort_q;
    assign seq_bus.composer_rd_idx      = rd_idx_q;
    assign seq_bus.composer_erase_start = erase_pulse;
    assign seq_bus.render_overrun       = rov_q;
    assign seq_bus.erase_overrun        = eov_q;

endmodule

// File: doc/sprite_line_sequencer.md
Name: sprite_line_sequencer

Overview:
- Sequences the double-buffered sprite line buffer.
- Owns the buffer-select bit and swaps buffers at each line boundary.
- Starts and aborts the sprite renderer, and triggers the line-erase after the composer finishes reading a line.
- Generates the composer read index and counts renderer/erase overruns for status.

Parameters:
- LINE_WIDTH, 640, visible pixels per line; composer read index range 0..LINE_WIDTH-1.
- ERASE_CYCLES, 160, cycles the buffer erase stays busy after composer_erase_start (LINE_WIDTH/4).
- START_DELAY, 2, cycles from buffer swap to render_start pulse (lets buffer mux settle).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  sprites enabled; when 0, no render_start or erase pulses are issued.
- line_swap  in  1  one-cycle strobe at start of horizontal blank.
- display_start  in  1  one-cycle strobe at first visible pixel.
- pix_en  in  1  composer consumes one pixel this cycle.
- display_end  in  1  one-cycle strobe after last visible pixel.
- render_done  in  1  renderer level: finished current line.
- status_clr  in  1  clears overrun counters and sticky flags.
- active_render_buffer  out  1  buffer select to line buffer.
- render_start  out  1  one-cycle pulse to renderer.
- render_abort  out  1  one-cycle pulse; renderer must stop.
- composer_rd_idx  out  10  composer read address.
- composer_erase_start  out  1  one-cycle pulse to line buffer.
- render_overrun  out  8  saturating count of aborted renders.
- erase_overrun  out  1  sticky: swap occurred while erase busy.

Behaviour:
- Reset values: every output 0; FSM enters IDLE; erase counter 0; delay counter 0.
- FSM states:
  - IDLE: no render in flight.
  - DELAY: counting START_DELAY.
  - RENDER: waiting on render_done.
  - DONE: render complete, awaiting swap.
- line_swap (any state, enable=1):
  - Toggle active_render_buffer on the next edge.
  - If state is RENDER: pulse render_abort the same cycle as the toggle, and increment render_overrun (saturating at 255).
  - Go to DELAY.
- DELAY: after START_DELAY cycles, pulse render_start for 1 cycle and go to RENDER. With START_DELAY=2, render_start is high exactly 2 cycles after the cycle active_render_buffer changes.
- RENDER: render_done=1 -> DONE. render_done is ignored in IDLE, DELAY and DONE.
- line_swap during DELAY: restart the delay; no abort, no counter increment, buffer toggles again.
- line_swap with enable=0: buffer still toggles, FSM forced to IDLE, no start. Abort is pulsed if the FSM was in RENDER; the counter is not incremented.
- enable falling mid-RENDER: pulse render_abort once, go to IDLE, no count.
- display_end with enable=1:
  - Pulse composer_erase_start the next cycle and load the erase counter with ERASE_CYCLES.
  - The counter decrements each cycle to 0; busy = counter != 0.
  - display_end while busy: reload the counter and pulse again.
- line_swap while erase busy: set erase_overrun (sticky); the swap still proceeds.
- composer_rd_idx:
  - display_start loads 0 (takes priority over pix_en in the same cycle).
  - pix_en increments it, saturating at LINE_WIDTH-1.
  - It holds otherwise.
- status_clr: zeroes render_overrun and erase_overrun next cycle. If an overrun event occurs in the same cycle, the event wins: count becomes 1 / flag set.
- Reset mid-operation: all state returns to reset values in one cycle, with no abort pulse. The renderer is reset by the same rst.
- All pulse outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared graphics package holds:
  - FSM state encoding (IDLE, DELAY, RENDER, DONE, 2 bits).
  - LINE_WIDTH default constant.
  - ERASE_CYCLES derivation (LINE_WIDTH/4, matching the line buffer's 4-way bank split).
- One natural sub-module: sprite_erase_timer (load/decrement busy counter with a registered start pulse). Everything else stays in one module.

Test Plan:
- Reset, enable=1, line_swap at cycle 10 -> active_render_buffer 0→1 at cycle 11, render_start high only at cycle 13; render_done at 50 -> no abort at the next swap; render_overrun=0.
- Renderer never asserts render_done; two line_swaps 800 cycles apart -> render_abort coincides with the second toggle; render_overrun=1; render_start follows 2 cycles later.
- display_end at cycle 0 -> composer_erase_start high at cycle 1 only; line_swap at cycle 100 -> erase_overrun=1; with line_swap at cycle 200 instead -> erase_overrun stays 0.
- display_start then 700 pix_en cycles -> composer_rd_idx steps 0..639 and holds at 639; display_start with pix_en in the same cycle -> index 0.
- 300 forced aborts -> render_overrun saturates at 255; status_clr coincident with an abort -> render_overrun=1.
- Deassert enable during RENDER -> one render_abort, count unchanged; subsequent line_swaps toggle the buffer with no render_start or erase pulses.
